// File: rtl/spi_pkg.sv
// Shared defaults and bit-order type for the SPI word slave and its shift registers.
package spi_pkg;

    localparam int DEFAULT_WIDTH = 8;
    localparam int DEFAULT_CNT_W = 8;

    typedef enum logic {
        MSB_FIRST = 1'b0,
        LSB_FIRST = 1'b1
    } spi_order_e;

endpackage

// File: rtl/spi_shift_reg.sv
// Direction-selectable shift register with parallel load.
// Exposes both its next-shift value and the bit leaving at the far end.
module spi_shift_reg
    import spi_pkg::*;
#(
    parameter int         WIDTH = DEFAULT_WIDTH,
    parameter spi_order_e ORDER = MSB_FIRST
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             shift,
    input  logic             shift_in,
    output logic [WIDTH-1:0] nxt,
    output logic             sout
);

    logic [WIDTH-1:0] q;

    // MSB-first shifts toward the MSB, so new bits enter at the LSB end.
    always_comb begin
        nxt = '0;
        if (ORDER == MSB_FIRST)
            nxt = {q[WIDTH-2:0], shift_in};
        else
            nxt = {shift_in, q[WIDTH-1:1]};
    end

    assign sout = (ORDER == MSB_FIRST) ? q[WIDTH-1] : q[0];

    always_ff @(posedge clk) begin
        if (clr)
            q <= '0;
        else if (load)
            q <= load_val;
        else if (shift)
            q <= nxt;
    end

endmodule

// File: rtl/spi_slave_word.sv
// SPI slave moving whole words: bit counter, framed RX word, TX shifter,
// sticky framing-error flag and completed-word counter. Clocked by sclk only.
module spi_slave_word #(
    parameter int WIDTH     = spi_pkg::DEFAULT_WIDTH,
    parameter int LSB_FIRST = 0,
    parameter int ECHO      = 0,
    parameter int CNT_W     = spi_pkg::DEFAULT_CNT_W
) (
    input  logic             sclk,
    input  logic             rst,
    input  logic             CS,
    input  logic             MOSI,
    input  logic [WIDTH-1:0] tx_data,
    output logic             MISO,
    output logic [WIDTH-1:0] rx_data,
    output logic             rx_valid,
    output logic             busy,
    output logic             frame_err,
    output logic [CNT_W-1:0] word_cnt
);

    import spi_pkg::*;

    localparam int         BIT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam spi_order_e ORDER = (LSB_FIRST != 0) ? spi_pkg::LSB_FIRST : spi_pkg::MSB_FIRST;

    logic [BIT_W-1:0] cnt;
    logic             last;
    logic             done;
    logic             start;

    logic [WIDTH-1:0] rx_word;
    logic             rx_sout_unused;
    logic [WIDTH-1:0] tx_load_val;
    logic             tx_first;
    logic             tx_next;
    logic [WIDTH-1:0] tx_nxt_unused;

    assign last  = (cnt == BIT_W'(WIDTH - 1));
    assign done  = !CS && last;
    assign start = !CS && (cnt == '0);
    assign busy  = (cnt != '0);

    // The first TX bit goes straight to MISO; the register holds the rest.
    always_comb begin
        tx_load_val = '0;
        tx_first    = 1'b0;
        if (ORDER == spi_pkg::MSB_FIRST) begin
            tx_load_val = {tx_data[WIDTH-2:0], 1'b0};
            tx_first    = tx_data[WIDTH-1];
        end else begin
            tx_load_val = {1'b0, tx_data[WIDTH-1:1]};
            tx_first    = tx_data[0];
        end
    end

    // Cleared on completion so a back-to-back word starts from zero.
    spi_shift_reg #(
        .WIDTH (WIDTH),
        .ORDER (ORDER)
    ) u_rx (
        .clk      (sclk),
        .clr      (rst || CS || done),
        .load     (1'b0),
        .load_val ('0),
        .shift    (!CS),
        .shift_in (MOSI),
        .nxt      (rx_word),
        .sout     (rx_sout_unused)
    );

    spi_shift_reg #(
        .WIDTH (WIDTH),
        .ORDER (ORDER)
    ) u_tx (
        .clk      (sclk),
        .clr      (rst || CS),
        .load     (start),
        .load_val (tx_load_val),
        .shift    (!CS),
        .shift_in (1'b0),
        .nxt      (tx_nxt_unused),
        .sout     (tx_next)
    );

    always_ff @(posedge sclk) begin
        if (rst) begin
            cnt       <= '0;
            MISO      <= 1'b0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            word_cnt  <= '0;
        end else begin
            rx_valid <= 1'b0;
            if (CS) begin
                // Abort: partial word is dropped, completed state holds.
                cnt  <= '0;
                MISO <= 1'b0;
                if (cnt != '0)
                    frame_err <= 1'b1;
            end else begin
                if (last) begin
                    cnt      <= '0;
                    rx_data  <= rx_word;
                    rx_valid <= 1'b1;
                    word_cnt <= word_cnt + CNT_W'(1);
                end else begin
                    cnt <= cnt + BIT_W'(1);
                end
                if (ECHO != 0)
                    MISO <= MOSI;
                else if (cnt == '0)
                    MISO <= tx_first;
                else
                    MISO <= tx_next;
            end
        end
    end

endmodule
